// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: picks the oldest mispredicting branch by ROB age, sequences it to the frontend, and queues predictor updates.
// Optional BRANCH_REDIRECT_PERF_EN adds saturating branch/mispredict counters.
module branch_redirect_ctrl #(
    parameter int BRU_NUM   = 2,
    parameter int ROB_IDX_W = 6,
    parameter int VALEN     = 32,
    parameter int UPD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BRU_NUM-1:0]           bru_valid_i,
    output logic                         bru_ready_o,
    input  logic [BRU_NUM*ROB_IDX_W-1:0] bru_rob_idx_i,
    input  logic [BRU_NUM*VALEN-1:0]     bru_pc_i,
    input  logic [BRU_NUM*VALEN-1:0]     bru_target_i,
    input  logic [BRU_NUM-1:0]           bru_redirect_i,
    input  logic [BRU_NUM-1:0]           bru_taken_i,
    input  logic [BRU_NUM*2-1:0]         bru_br_type_i,
    input  logic [ROB_IDX_W-1:0]         rob_head_idx_i,
    input  logic                         rob_flush_i,
    input  logic                         squash_done_i,
    output logic                         redirect_valid_o,
    input  logic                         redirect_ready_i,
    output logic [VALEN-1:0]             redirect_pc_o,
    output logic [ROB_IDX_W-1:0]         redirect_rob_idx_o,
    output logic                         upd_valid_o,
    input  logic                         upd_ready_i,
    output logic [VALEN-1:0]             upd_pc_o,
    output logic [VALEN-1:0]             upd_target_o,
    output logic                         upd_taken_o,
    output logic [1:0]                   upd_br_type_o,
    output logic                         upd_mispred_o,
    output logic [1:0]                   dbg_state
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]                  perf_br_cnt_o,
    output logic [31:0]                  perf_mispred_cnt_o
`endif
);

    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = $clog2(UPD_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_SQUASH = 2'd2} state_t;

    typedef struct packed {
        logic [VALEN-1:0] pc;
        logic [VALEN-1:0] target;
        logic             taken;
        logic [1:0]       br_type;
        logic             mispred;
    } upd_t;

    state_t                 state_q, state_d;
    logic [VALEN-1:0]       held_pc_q, held_pc_d;
    logic [ROB_IDX_W-1:0]   held_idx_q, held_idx_d;
    logic [ROB_IDX_W-1:0]   held_age;
    logic [ROB_IDX_W-1:0]   lane_idx [BRU_NUM];
    logic [ROB_IDX_W-1:0]   lane_age [BRU_NUM];
    logic [BRU_NUM-1:0]     lane_kill, live;
    upd_t                   lane_ent [BRU_NUM];
    logic                   cand_found, cand_older;
    logic [ROB_IDX_W-1:0]   cand_age, cand_idx;
    logic [VALEN-1:0]       cand_pc;

    upd_t                   fifo_mem [UPD_DEPTH];
    upd_t                   head_ent;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]       push_slot [BRU_NUM];
    logic [CNT_W-1:0]       count_q, count_d, push_cnt, free_d;
    logic                   pop, ready_d;

    // Age is distance from the ROB head; a lane in the shadow of the held redirect is squashed.
    always_comb begin
        held_age   = held_idx_q - rob_head_idx_i;
        lane_kill  = '0;
        live       = '0;
        cand_found = 1'b0;
        cand_age   = '0;
        cand_idx   = '0;
        cand_pc    = '0;
        for (int i = 0; i < BRU_NUM; i++) begin
            lane_idx[i]  = bru_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
            lane_age[i]  = lane_idx[i] - rob_head_idx_i;
            lane_ent[i]  = {bru_pc_i[i*VALEN +: VALEN], bru_target_i[i*VALEN +: VALEN],
                            bru_taken_i[i], bru_br_type_i[i*2 +: 2], bru_redirect_i[i]};
            lane_kill[i] = (state_q == S_SQUASH && lane_age[i] >= held_age) ||
                           (state_q == S_HOLD   && lane_age[i] >  held_age);
            live[i]      = bru_valid_i[i] && bru_ready_o && !lane_kill[i] && !rob_flush_i;
            if (live[i] && bru_redirect_i[i] && (!cand_found || lane_age[i] < cand_age)) begin
                cand_found = 1'b1;
                cand_age   = lane_age[i];
                cand_idx   = lane_idx[i];
                cand_pc    = bru_target_i[i*VALEN +: VALEN];
            end
        end
        cand_older = cand_found && (state_q == S_IDLE || cand_age < held_age);
    end

    always_comb begin
        state_d    = state_q;
        held_pc_d  = held_pc_q;
        held_idx_d = held_idx_q;
        if (rob_flush_i) begin
            state_d = S_IDLE;
        end else if (cand_older) begin
            // An older mispredict always wins, even over a same-cycle handshake or squash_done.
            state_d    = S_HOLD;
            held_pc_d  = cand_pc;
            held_idx_d = cand_idx;
        end else begin
            case (state_q)
                S_HOLD:   if (redirect_ready_i) state_d = S_SQUASH;
                S_SQUASH: if (squash_done_i)    state_d = S_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            held_pc_q  <= '0;
            held_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            held_pc_q  <= held_pc_d;
            held_idx_q <= held_idx_d;
        end
    end

    assign redirect_valid_o   = (state_q == S_HOLD);
    assign redirect_pc_o      = held_pc_q;
    assign redirect_rob_idx_o = held_idx_q;
    assign dbg_state          = state_q;

    // Live lanes are packed into consecutive slots in lane order.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < BRU_NUM; i++) begin
            push_slot[i] = wr_ptr_q + push_cnt[PTR_W-1:0];
            if (live[i]) push_cnt = push_cnt + CNT_W'(1);
        end
        pop     = upd_valid_o && upd_ready_i;
        count_d = count_q + push_cnt - CNT_W'(pop);
        free_d  = CNT_W'(UPD_DEPTH) - count_d;
        ready_d = (free_d >= CNT_W'(BRU_NUM));
    end

    always_ff @(posedge clk) begin
        if (rst || rob_flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bru_ready_o <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_q + push_cnt[PTR_W-1:0];
            rd_ptr_q    <= rd_ptr_q + PTR_W'(pop);
            count_q     <= count_d;
            bru_ready_o <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BRU_NUM; i++) begin
            if (live[i]) fifo_mem[push_slot[i]] <= lane_ent[i];
        end
    end

    // Data outputs read as zero while the FIFO is empty.
    assign head_ent      = fifo_mem[rd_ptr_q];
    assign upd_valid_o   = (count_q != '0);
    assign upd_pc_o      = upd_valid_o ? head_ent.pc      : '0;
    assign upd_target_o  = upd_valid_o ? head_ent.target  : '0;
    assign upd_taken_o   = upd_valid_o ? head_ent.taken   : 1'b0;
    assign upd_br_type_o = upd_valid_o ? head_ent.br_type : 2'b00;
    assign upd_mispred_o = upd_valid_o ? head_ent.mispred : 1'b0;

`ifdef BRANCH_REDIRECT_PERF_EN
    logic [32:0] br_sum, mp_sum;

    always_comb begin
        br_sum = {1'b0, perf_br_cnt_o};
        mp_sum = {1'b0, perf_mispred_cnt_o};
        for (int i = 0; i < BRU_NUM; i++) begin
            br_sum = br_sum + 33'(live[i]);
            mp_sum = mp_sum + 33'(live[i] & bru_redirect_i[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_cnt_o      <= '0;
            perf_mispred_cnt_o <= '0;
        end else begin
            perf_br_cnt_o      <= br_sum[32] ? 32'hFFFF_FFFF : br_sum[31:0];
            perf_mispred_cnt_o <= mp_sum[32] ? 32'hFFFF_FFFF : mp_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sits between the BRU_NUM branch-unit lanes and the frontend/BPU. It collects resolved branch results each cycle and selects the oldest mispredict by ROB age.
- The selected mispredict is held and sequenced to the frontend as a single redirect handshake. Results younger than an accepted redirect are squashed until the ROB reports the flush complete.
- Predictor updates for surviving branches are queued in a small FIFO toward the BPU.

Parameters:
- BRU_NUM, 2, number of branch-unit lanes (1..4)
- ROB_IDX_W, 6, ROB index width
- VALEN, 32, virtual address width (matches PROC_VALEN)
- UPD_DEPTH, 4, predictor-update FIFO entries; must be >= BRU_NUM and a power of two

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bru_valid_i  in  BRU_NUM  lane carries a resolved branch this cycle
- bru_ready_o  out  1  all lanes may present results; low when FIFO free entries < BRU_NUM
- bru_rob_idx_i  in  BRU_NUM*ROB_IDX_W  ROB index per lane
- bru_pc_i  in  BRU_NUM*VALEN  branch PC per lane
- bru_target_i  in  BRU_NUM*VALEN  resolved next PC per lane
- bru_redirect_i  in  BRU_NUM  resolved next PC differs from the predicted one
- bru_taken_i  in  BRU_NUM  resolved direction
- bru_br_type_i  in  BRU_NUM*2  CALL/RETURN/ABSOLUTE/PC_RELATIVE code
- rob_head_idx_i  in  ROB_IDX_W  current ROB head, used for age
- rob_flush_i  in  1  global flush (exception/ertn); clears everything
- squash_done_i  in  1  ROB/rename have finished the backend flush for the last redirect
- redirect_valid_o  out  1  redirect request to frontend
- redirect_ready_i  in  1  frontend accepts redirect
- redirect_pc_o  out  VALEN  redirect target
- redirect_rob_idx_o  out  ROB_IDX_W  ROB index of the redirecting branch (flush point)
- upd_valid_o  out  1  BPU update available
- upd_ready_i  in  1  BPU consumes update
- upd_pc_o  out  VALEN  update PC
- upd_target_o  out  VALEN  update target
- upd_taken_o  out  1  update direction
- upd_br_type_o  out  2  update branch type
- upd_mispred_o  out  1  this update was a mispredict

Behaviour:
- Reset: state IDLE; all *_valid_o = 0; redirect_pc_o / redirect_rob_idx_o = 0; FIFO empty; bru_ready_o = 1; upd_* data outputs = 0.
- Age: age(i) = (idx - rob_head_idx_i) mod 2^ROB_IDX_W; smaller is older. Ties are impossible.
- A lane is live when bru_valid_i = 1, bru_ready_o = 1, and the lane is not squashed.
  - In SQUASH, a lane is squashed if its age >= age(held idx).
  - In HOLD, a lane is squashed if its age > age(held idx).
- Oldest live lane with bru_redirect_i = 1 is the cycle's candidate.
- States:
  - IDLE:
    - candidate -> capture it into the held register (target, rob_idx); go to HOLD.
    - redirect_valid_o is registered and asserts the cycle after capture (1-cycle latency).
  - HOLD:
    - redirect_valid_o = 1. A candidate older than the held entry replaces it.
    - Handshake (valid & ready) -> go to SQUASH, unless an older candidate arrives in the same cycle. In that case the older candidate is captured and the state stays in HOLD.
  - SQUASH:
    - redirect_valid_o = 0. Lanes at or younger than the held idx are dropped (no FIFO push).
    - An older candidate re-captures and returns to HOLD.
    - squash_done_i -> go to IDLE.
- Update FIFO:
  - Every live lane pushes one entry per cycle, in lane order, oldest-first not required. Up to BRU_NUM pushes per cycle; one pop per upd_valid_o & upd_ready_i.
  - Push and pop in the same cycle are allowed. Pointers wrap modulo UPD_DEPTH. Count never exceeds UPD_DEPTH.
  - bru_ready_o is registered from the next-cycle free count (free >= BRU_NUM).
- rob_flush_i (highest priority, any state):
  - Go to IDLE, clear redirect_valid_o, empty the FIFO.
  - Lane inputs that cycle are ignored.
- Redirect data stays stable while redirect_valid_o = 1, except for an older-candidate replacement.

Optional Feature:
- BRANCH_REDIRECT_PERF_EN defined: adds outputs perf_br_cnt_o[31:0] (live branches) and perf_mispred_cnt_o[31:0] (live lanes with bru_redirect_i).
  - Counters increment by the number of qualifying lanes per cycle and saturate at 0xFFFFFFFF.
  - Reset to 0 on rst only; rob_flush_i does not clear them.
- Undefined: ports absent, no counter logic.

Test Plan:
- Single redirect: head=0, lane0 idx=5 redirect target=0x1C000040, ready=1 -> redirect_valid_o high next cycle with pc=0x1C000040, rob_idx=5. One FIFO entry with mispred=1. State SQUASH until squash_done_i.
- Age selection with wrap: head=60, lane0 idx=2, lane1 idx=62, both redirect -> idx 62 chosen (age 2 < age 6).
- Replacement in HOLD: ready=0, held idx=10; next cycle lane idx=8 redirects -> held becomes idx 8; idx 12 redirect ignored and not pushed.
- Squash filtering: in SQUASH with held idx=8, lanes idx=9 and idx=7 non-redirect -> only idx 7 pushed; squash_done_i -> IDLE.
- FIFO backpressure: upd_ready_i=0, UPD_DEPTH=4, 2 lanes pushing -> after 2 cycles bru_ready_o=0, count=4. Release upd_ready_i -> entries pop in push order.
- rob_flush_i in HOLD with 3 FIFO entries -> next cycle redirect_valid_o=0, upd_valid_o=0, bru_ready_o=1.
